// File: rtl/f16_bus_ctrl.sv
// Bus transceiver / device strobe sequencer for a 16-bit host port split into two 8-bit lanes.
// Runs a TURN/SETUP/STROBE/HOLD sequence with programmable timing; every output is registered.
module f16_bus_ctrl #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        wr,
  input  logic [1:0]  be,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        busy,
  output logic        done,
  output logic        dir1,
  output logic        dir2,
  output logic        cs1_n,
  output logic        cs2_n,
  output logic [15:0] a_out,
  output logic        a_oe,
  input  logic [15:0] a_in,
  output logic        wr_n,
  output logic        rd_n
);

  typedef enum logic [2:0] {IDLE, TURN, SETUP, STROBE, HOLD} state_t;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        wr_reg, wr_next;
  logic [1:0]  be_reg, be_next;
  logic        dir1_reg, dir1_next, dir2_reg, dir2_next;
  logic        cs1_n_reg, cs1_n_next, cs2_n_reg, cs2_n_next;
  logic        wr_n_reg, wr_n_next, rd_n_reg, rd_n_next;
  logic        a_oe_reg, a_oe_next;
  logic [15:0] a_out_reg, a_out_next;
  logic [15:0] data_out_reg, data_out_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        need_turn;

  // A turnaround is only needed when an enabled lane points the wrong way.
  assign need_turn = (be[0] && (dir1_reg != wr)) || (be[1] && (dir2_reg != wr));

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    wr_next       = wr_reg;
    be_next       = be_reg;
    dir1_next     = dir1_reg;
    dir2_next     = dir2_reg;
    cs1_n_next    = cs1_n_reg;
    cs2_n_next    = cs2_n_reg;
    wr_n_next     = wr_n_reg;
    rd_n_next     = rd_n_reg;
    a_oe_next     = a_oe_reg;
    a_out_next    = a_out_reg;
    data_out_next = data_out_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        busy_next  = 1'b0;
        cs1_n_next = 1'b1;
        cs2_n_next = 1'b1;
        wr_n_next  = 1'b1;
        rd_n_next  = 1'b1;
        a_oe_next  = 1'b0;
        if (start && (be != 2'b00)) begin
          wr_next    = wr;
          be_next    = be;
          a_out_next = data_in;
          busy_next  = 1'b1;
          if (need_turn) begin
            state_next = TURN;
            if (be[0]) dir1_next = wr;
            if (be[1]) dir2_next = wr;
          end else begin
            state_next = SETUP;
            cnt_next   = SETUP_LD;
            cs1_n_next = !be[0];
            cs2_n_next = !be[1];
            a_oe_next  = wr;
          end
        end
      end

      TURN: begin
        state_next = SETUP;
        cnt_next   = SETUP_LD;
        cs1_n_next = !be_reg[0];
        cs2_n_next = !be_reg[1];
        a_oe_next  = wr_reg;
      end

      SETUP: begin
        if (cnt_reg == 4'd0) begin
          state_next = STROBE;
          cnt_next   = STROBE_LD;
          wr_n_next  = !wr_reg;
          rd_n_next  = wr_reg;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end

      STROBE: begin
        if (cnt_reg == 4'd0) begin
          state_next = HOLD;
          cnt_next   = HOLD_LD;
          wr_n_next  = 1'b1;
          rd_n_next  = 1'b1;
          // Read data is captured on the edge that ends the strobe.
          if (!wr_reg) begin
            if (be_reg[0]) data_out_next[7:0]  = a_in[7:0];
            if (be_reg[1]) data_out_next[15:8] = a_in[15:8];
          end
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end

      HOLD: begin
        if (cnt_reg == 4'd0) begin
          state_next = IDLE;
          cs1_n_next = 1'b1;
          cs2_n_next = 1'b1;
          a_oe_next  = 1'b0;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      wr_reg       <= 1'b0;
      be_reg       <= 2'b00;
      dir1_reg     <= 1'b0;
      dir2_reg     <= 1'b0;
      cs1_n_reg    <= 1'b1;
      cs2_n_reg    <= 1'b1;
      wr_n_reg     <= 1'b1;
      rd_n_reg     <= 1'b1;
      a_oe_reg     <= 1'b0;
      a_out_reg    <= 16'h0000;
      data_out_reg <= 16'h0000;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      wr_reg       <= wr_next;
      be_reg       <= be_next;
      dir1_reg     <= dir1_next;
      dir2_reg     <= dir2_next;
      cs1_n_reg    <= cs1_n_next;
      cs2_n_reg    <= cs2_n_next;
      wr_n_reg     <= wr_n_next;
      rd_n_reg     <= rd_n_next;
      a_oe_reg     <= a_oe_next;
      a_out_reg    <= a_out_next;
      data_out_reg <= data_out_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  assign data_out = data_out_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign dir1     = dir1_reg;
  assign dir2     = dir2_reg;
  assign cs1_n    = cs1_n_reg;
  assign cs2_n    = cs2_n_reg;
  assign a_out    = a_out_reg;
  assign a_oe     = a_oe_reg;
  assign wr_n     = wr_n_reg;
  assign rd_n     = rd_n_reg;

endmodule

// File: doc/f16_bus_ctrl.md
# f16_bus_ctrl

Synchronous sequencer that drives the control side of the dual 8-bit bus transceiver pair (lanes 1 and 2) and the external device strobes. It accepts a 16-bit read or write request from the host logic and generates DIR1/_CS1/DIR2/_CS2, host-side A-bus drive enable and data, and _WR/_RD, with programmable setup/strobe/hold timing. DIR never changes while the matching _CS is low, so the transceivers never see a direction switch while enabled.

## Interface
- SETUP_CYC, 1: cycles _CS is low before the strobe (1..15)
- STROBE_CYC, 2: cycles _WR/_RD is low (1..15)
- HOLD_CYC, 1: cycles _CS stays low after the strobe (1..15)
- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous reset, active high
- START  in  1  request pulse; sampled only in IDLE
- WR  in  1  1 = write (host→device), 0 = read
- BE  in  2  lane enables: bit0 = lane 1 (A_1, low byte), bit1 = lane 2 (A_2, high byte)
- DATA_IN  in  16  write data, latched at accept
- DATA_OUT  out  16  read data, per enabled lane
- BUSY  out  1  transfer in progress
- DONE  out  1  one-cycle completion pulse
- DIR1, DIR2  out  1  transceiver direction: 1 = A→B (write), 0 = B→A (read)
- _CS1, _CS2  out  1  transceiver enables, active low
- A_OUT  out  16  host-side A-bus drive data ([7:0]→A_1, [15:8]→A_2)
- A_OE  out  1  host drives A bus when 1
- A_IN  in  16  host-side A-bus sample
- _WR, _RD  out  1  device strobes, active low

## Operation
- States: IDLE, TURN, SETUP, STROBE, HOLD. One 4-bit down-counter is shared across timed states.
- IDLE: _CSn = 1, _WR = _RD = 1, A_OE = 0, BUSY = 0. On START = 1 with BE ≠ 0, latch WR, BE, and DATA_IN into A_OUT, then leave IDLE. START with BE = 0 is ignored: no state change, no DONE.
- Turnaround: if any enabled lane's current DIRn ≠ WR, go to TURN. Otherwise go to SETUP.
- TURN (1 cycle): DIRn ← WR for the enabled lanes; all _CS stay high; then SETUP.
- SETUP (SETUP_CYC cycles): _CSn = 0 for the enabled lanes; A_OE = WR.
- STROBE (STROBE_CYC cycles): _WR = 0 if writing, otherwise _RD = 0. On a read, the clock edge that ends STROBE loads A_IN bytes into DATA_OUT for the enabled lanes. Disabled lanes of DATA_OUT keep their value.
- HOLD (HOLD_CYC cycles): strobes high, _CS still low, A_OE unchanged. Then go to IDLE with DONE = 1 for exactly one cycle.
- Disabled lanes: their DIRn and _CSn (high) are untouched for the whole transfer.
- A_OE is never 1 while the enabled lanes have DIR = 0 and _CS = 0.
- Reset values: DIR1 = DIR2 = 0, _CS1 = _CS2 = 1, _WR = _RD = 1, A_OE = 0, A_OUT = 0, DATA_OUT = 0, BUSY = 0, DONE = 0, state IDLE.
- RST mid-transfer: all outputs take reset values at the next edge. No DONE, no DATA_OUT update.

## Timing
- All outputs are registered. "Edge 0" is the edge that samples START.
- No turnaround: SETUP occupies cycles 1..S, STROBE S+1..S+T, HOLD S+T+1..S+T+H, DONE in cycle S+T+H+1. Defaults give DONE in cycle 5.
- With turnaround: everything shifts by +1, so DONE is in cycle 6 with defaults.
- BUSY is high from cycle 1 through the last HOLD cycle and low in the DONE cycle.
- START in the DONE cycle is accepted, giving back-to-back transfers with _CS high for 1 cycle between them.
- START while BUSY = 1 is ignored, not queued.
- DATA_OUT is valid from the DONE cycle and holds until the next read.

## Test plan
- Reset, then 16-bit write: WR = 1, BE = 11, DATA_IN = 0xA55A, DIR at reset value 0. Required: TURN in cycle 1 (DIR1 = DIR2 = 1, _CS high); _CS1 = _CS2 = 0 in cycles 2–5; _WR = 0 in cycles 3–4; A_OUT = 0xA55A and A_OE = 1 in cycles 2–5; DONE in cycle 6.
- 16-bit read straight after the write: WR = 0, BE = 11, A_IN = 0x1234 during STROBE. Required: TURN to DIR = 0 with _CS high; A_OE = 0 throughout; _RD low for 2 cycles; DATA_OUT = 0x1234 at DONE.
- Second read, same direction: no TURN cycle; DONE at cycle 5.
- Lane-2-only write: BE = 10, DATA_IN = 0xBEEF. Required: _CS1 stays 1 and DIR1 unchanged; _CS2 low; A_OUT[15:8] = 0xBE.
- START pulsed during BUSY, and START with BE = 00 in IDLE: both ignored, exactly one DONE for the original transfer. Also START in the DONE cycle: next transfer starts with a single _CS-high gap.
- RST asserted during STROBE of a read: next edge gives _CS = 1, _RD = 1, DIR = 0, BUSY = 0, DATA_OUT = 0, and no DONE.
